mem_arbiter: RTL and testbench

- Memory arbiter directly downstream of `softreset` and the other memory clients.
- Accepts addr/data/op requests from `NUM_CLIENTS` clients over rts/rtr handshakes and grants one per cycle by round-robin.
- Forwards the granted request through a single registered stage to the frame-memory port.
- Routes in-order read data back to the issuing client, tracking it in an outstanding-read ID FIFO.

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/rd_id_fifo.sv | 47 ++++
 rtl/mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared memory-port definitions: opcodes and the default bus widths used by
// softreset and the other frame-memory clients.
package mem_arb_pkg;

  localparam int MEM_ADDR_W = 17;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_OP_W   = 4;

  typedef enum logic [MEM_OP_W-1:0] {
    OP_NOP   = 4'd0,
    OP_WRITE = 4'd1,
    OP_READ  = 4'd2
  } mem_op_e;

endpackage

// File: rtl/rd_id_fifo.sv
// Synchronous FIFO of client IDs for reads issued to memory but not yet returned.
module rd_id_fifo #(
  parameter  int W     = 2,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     wr_id,
  output logic [W-1:0]     rd_id,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  logic [W-1:0]     id_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_id   = id_q[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) id_q[wr_ptr] <= wr_id;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter in front of the frame-memory port: one registered request
// stage toward memory, in-order read data routed back by an ID FIFO.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int NUM_CLIENTS = 3,
  parameter  int ADDR_W      = MEM_ADDR_W,
  parameter  int DATA_W      = MEM_DATA_W,
  parameter  int OP_W        = MEM_OP_W,
  parameter  int RD_DEPTH    = 4,
  localparam int ID_W        = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1,
  localparam int CNT_W       = $clog2(RD_DEPTH) + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] cli_addr,
  input  logic [NUM_CLIENTS*DATA_W-1:0] cli_wr_data,
  input  logic [NUM_CLIENTS*OP_W-1:0]   cli_op,
  input  logic [NUM_CLIENTS-1:0]        cli_rts_in,
  output logic [NUM_CLIENTS-1:0]        cli_rtr_out,
  output logic [DATA_W-1:0]             cli_rd_data,
  output logic [NUM_CLIENTS-1:0]        cli_rd_valid,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wr_data,
  output logic [OP_W-1:0]               mem_op,
  output logic                          mem_rts_out,
  input  logic                          mem_rtr_in,
  input  logic [DATA_W-1:0]             mem_rd_data_in,
  input  logic                          mem_rd_valid_in,
  output logic                          rd_err
);

  logic [ID_W-1:0]        rr_ptr;
  logic [NUM_CLIENTS-1:0] is_read;
  logic [NUM_CLIENTS-1:0] is_fwd;
  logic [NUM_CLIENTS-1:0] cand;
  logic                   found;
  logic                   grant;
  logic                   can_load;
  logic [ID_W-1:0]        gnt_idx;
  logic [ID_W:0]          srch;
  logic [ADDR_W-1:0]      g_addr;
  logic [DATA_W-1:0]      g_data;
  logic [OP_W-1:0]        g_op;
  logic                   g_read;
  logic                   g_fwd;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [ID_W-1:0]        fifo_rd_id;
  logic [CNT_W-1:0]       fifo_count;
  logic                   rd_pop;

  for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_cli
    logic [OP_W-1:0] op;
    assign op         = cli_op[i*OP_W +: OP_W];
    assign is_read[i] = (op == OP_W'(OP_READ));
    assign is_fwd[i]  = (op == OP_W'(OP_READ)) || (op == OP_W'(OP_WRITE));
    // A read can't be issued when there is no room to remember who asked.
    assign cand[i]    = cli_rts_in[i] && !(is_read[i] && fifo_full);
  end

  assign can_load = !mem_rts_out || mem_rtr_in;

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    srch    = '0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      srch = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (srch >= (ID_W+1)'(NUM_CLIENTS)) srch = srch - (ID_W+1)'(NUM_CLIENTS);
      if (!found && cand[srch[ID_W-1:0]]) begin
        found   = 1'b1;
        gnt_idx = srch[ID_W-1:0];
      end
    end
  end

  always_comb begin
    g_addr = '0;
    g_data = '0;
    g_op   = '0;
    g_read = 1'b0;
    g_fwd  = 1'b0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (gnt_idx == ID_W'(i)) begin
        g_addr = cli_addr[i*ADDR_W +: ADDR_W];
        g_data = cli_wr_data[i*DATA_W +: DATA_W];
        g_op   = cli_op[i*OP_W +: OP_W];
        g_read = is_read[i];
        g_fwd  = is_fwd[i];
      end
    end
  end

  assign grant       = can_load && found;
  assign cli_rtr_out = grant ? (NUM_CLIENTS'(1) << gnt_idx) : '0;
  assign rd_pop      = mem_rd_valid_in && !fifo_empty;

  rd_id_fifo #(
    .W     (ID_W),
    .DEPTH (RD_DEPTH)
  ) u_rd_id_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (grant && g_read),
    .pop   (rd_pop),
    .wr_id (gnt_idx),
    .rd_id (fifo_rd_id),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Request stage: grant -> registered memory request
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= '0;
      mem_rts_out <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      mem_op      <= '0;
    end else begin
      if (grant) begin
        rr_ptr <= (gnt_idx == ID_W'(NUM_CLIENTS - 1)) ? '0 : gnt_idx + 1'b1;
      end
      if (grant && g_fwd) begin
        mem_addr    <= g_addr;
        mem_wr_data <= g_data;
        mem_op      <= g_op;
        mem_rts_out <= 1'b1;
      end else if (mem_rtr_in) begin
        mem_rts_out <= 1'b0;
      end
    end
  end

  // Return stage: memory read data -> issuing client
  always_ff @(posedge clk) begin
    if (rst) begin
      cli_rd_valid <= '0;
      cli_rd_data  <= '0;
      rd_err       <= 1'b0;
    end else begin
      cli_rd_valid <= rd_pop ? (NUM_CLIENTS'(1) << fifo_rd_id) : '0;
      if (rd_pop) cli_rd_data <= mem_rd_data_in;
      if (mem_rd_valid_in && fifo_empty) rd_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: round-robin order, stalls, read-ID tracking,
// orphan read returns and mid-operation reset.
module tb_mem_arbiter;
  localparam int N  = 3;
  localparam int AW = 17;
  localparam int DW = 32;
  localparam int OW = 4;

  logic            clk;
  logic            rst;
  logic [N*AW-1:0] cli_addr;
  logic [N*DW-1:0] cli_wr_data;
  logic [N*OW-1:0] cli_op;
  logic [N-1:0]    cli_rts_in;
  logic [N-1:0]    cli_rtr_out;
  logic [DW-1:0]   cli_rd_data;
  logic [N-1:0]    cli_rd_valid;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wr_data;
  logic [OW-1:0]   mem_op;
  logic            mem_rts_out;
  logic            mem_rtr_in;
  logic [DW-1:0]   mem_rd_data_in;
  logic            mem_rd_valid_in;
  logic            rd_err;

  int total  = 0;
  int passed = 0;

  mem_arbiter #(.NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .OP_W(OW), .RD_DEPTH(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .cli_addr        (cli_addr),
    .cli_wr_data     (cli_wr_data),
    .cli_op          (cli_op),
    .cli_rts_in      (cli_rts_in),
    .cli_rtr_out     (cli_rtr_out),
    .cli_rd_data     (cli_rd_data),
    .cli_rd_valid    (cli_rd_valid),
    .mem_addr        (mem_addr),
    .mem_wr_data     (mem_wr_data),
    .mem_op          (mem_op),
    .mem_rts_out     (mem_rts_out),
    .mem_rtr_in      (mem_rtr_in),
    .mem_rd_data_in  (mem_rd_data_in),
    .mem_rd_valid_in (mem_rd_valid_in),
    .rd_err          (rd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int c, input logic [OW-1:0] op,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    cli_addr[c*AW +: AW]    = a;
    cli_wr_data[c*DW +: DW] = d;
    cli_op[c*OW +: OW]      = op;
    cli_rts_in[c]           = 1'b1;
    #1;
  endtask

  task automatic clear_req();
    cli_rts_in = '0;
    cli_op     = '0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    total++; if (cli_rtr_out !== 3'b000) $display("FAIL reset_rtr: got %b want 000", cli_rtr_out); else passed++;
    total++; if (mem_rts_out !== 1'b0) $display("FAIL reset_rts: got %b want 0", mem_rts_out); else passed++;
    total++; if ({mem_addr, mem_wr_data, mem_op} !== '0) $display("FAIL reset_payload: got %h/%h/%h want 0", mem_addr, mem_wr_data, mem_op); else passed++;
    total++; if ({cli_rd_valid, cli_rd_data, rd_err} !== '0) $display("FAIL reset_rd: got %b/%h/%b want 0", cli_rd_valid, cli_rd_data, rd_err); else passed++;
  endtask

  task automatic test_round_robin();
    mem_rtr_in = 1'b1;
    for (int c = 0; c < N; c++) set_req(c, 4'd1, AW'(17'h100 + c), DW'(32'hC0DE_0000 + c));
    for (int k = 0; k < 6; k++) begin
      logic [N-1:0] exp_g;
      exp_g = N'(1) << (k % 3);
      total++; if (cli_rtr_out !== exp_g) $display("FAIL rr_grant%0d: got %b want %b", k, cli_rtr_out, exp_g); else passed++;
      step();
      total++; if (mem_rts_out !== 1'b1 || mem_addr !== AW'(17'h100 + k % 3))
        $display("FAIL rr_issue%0d: got rts=%b addr=%h want rts=1 addr=%h", k, mem_rts_out, mem_addr, 17'h100 + k % 3);
      else passed++;
    end
    clear_req();
    step();
  endtask

  task automatic test_single_write();
    set_req(0, 4'd1, 17'h1FFFF, 32'hDEADBEEF);
    total++; if (cli_rtr_out !== 3'b001) $display("FAIL wr_grant: got %b want 001", cli_rtr_out); else passed++;
    step();
    clear_req();
    total++; if (mem_rts_out !== 1'b1 || mem_addr !== 17'h1FFFF || mem_op !== 4'd1 || mem_wr_data !== 32'hDEADBEEF)
      $display("FAIL wr_issue: got rts=%b addr=%h op=%h data=%h want 1/1ffff/1/deadbeef", mem_rts_out, mem_addr, mem_op, mem_wr_data);
    else passed++;
  endtask

  task automatic test_stall();
    mem_rtr_in = 1'b0;
    set_req(1, 4'd1, 17'h0AAAA, 32'h5555_5555);
    for (int k = 0; k < 3; k++) begin
      total++; if (cli_rtr_out !== 3'b000 || mem_rts_out !== 1'b1 || mem_addr !== 17'h1FFFF || mem_wr_data !== 32'hDEADBEEF)
        $display("FAIL stall%0d: got rtr=%b rts=%b addr=%h data=%h want 000/1/1ffff/deadbeef", k, cli_rtr_out, mem_rts_out, mem_addr, mem_wr_data);
      else passed++;
      step();
    end
    mem_rtr_in = 1'b1;
    #1;
    total++; if (cli_rtr_out !== 3'b010) $display("FAIL stall_release: got %b want 010", cli_rtr_out); else passed++;
    step();
    clear_req();
    total++; if (mem_addr !== 17'h0AAAA || mem_rts_out !== 1'b1) $display("FAIL stall_next: got addr=%h rts=%b want 0aaaa/1", mem_addr, mem_rts_out); else passed++;
    step();
    total++; if (mem_rts_out !== 1'b0) $display("FAIL stall_drain: got %b want 0", mem_rts_out); else passed++;
  endtask

  task automatic test_read_full();
    set_req(2, 4'd2, 17'h00010, 32'h0);
    for (int k = 0; k < 4; k++) begin
      total++; if (cli_rtr_out !== 3'b100) $display("FAIL rd_issue%0d: got %b want 100", k, cli_rtr_out); else passed++;
      step();
    end
    set_req(1, 4'd1, 17'h00020, 32'h1);
    total++; if (cli_rtr_out !== 3'b010) $display("FAIL rd_full_wr: got %b want 010", cli_rtr_out); else passed++;
    step();
    cli_rts_in[1] = 1'b0;
    #1;
    total++; if (cli_rtr_out !== 3'b000) $display("FAIL rd_full_block: got %b want 000", cli_rtr_out); else passed++;
    mem_rd_valid_in = 1'b1;
    mem_rd_data_in  = 32'h12345678;
    step();
    mem_rd_valid_in = 1'b0;
    #1;
    total++; if (cli_rd_valid !== 3'b100 || cli_rd_data !== 32'h12345678)
      $display("FAIL rd_return: got valid=%b data=%h want 100/12345678", cli_rd_valid, cli_rd_data);
    else passed++;
    total++; if (cli_rtr_out !== 3'b100) $display("FAIL rd_unblock: got %b want 100", cli_rtr_out); else passed++;
    step();
    clear_req();
    for (int k = 0; k < 4; k++) begin
      mem_rd_valid_in = 1'b1;
      mem_rd_data_in  = 32'hA0 + k;
      step();
      total++; if (cli_rd_valid !== 3'b100 || cli_rd_data !== 32'hA0 + k)
        $display("FAIL rd_drain%0d: got valid=%b data=%h want 100/%h", k, cli_rd_valid, cli_rd_data, 32'hA0 + k);
      else passed++;
    end
    mem_rd_valid_in = 1'b0;
    #1;
    total++; if (rd_err !== 1'b0) $display("FAIL rd_err_clean: got %b want 0", rd_err); else passed++;
  endtask

  task automatic test_orphan_return();
    mem_rd_valid_in = 1'b1;
    mem_rd_data_in  = 32'h00000BAD;
    step();
    mem_rd_valid_in = 1'b0;
    #1;
    total++; if (cli_rd_valid !== 3'b000) $display("FAIL orphan_valid: got %b want 000", cli_rd_valid); else passed++;
    for (int k = 0; k < 3; k++) begin
      total++; if (rd_err !== 1'b1) $display("FAIL orphan_err%0d: got %b want 1", k, rd_err); else passed++;
      step();
    end
  endtask

  task automatic test_reset_mid();
    set_req(1, 4'd2, 17'h00030, 32'h0);
    step();
    step();
    clear_req();
    mem_rtr_in = 1'b0;
    #1;
    total++; if (mem_rts_out !== 1'b1) $display("FAIL mid_pending: got %b want 1", mem_rts_out); else passed++;
    rst = 1'b1;
    step();
    total++; if ({cli_rtr_out, cli_rd_valid, mem_rts_out, mem_addr, mem_wr_data, mem_op, cli_rd_data, rd_err} !== '0)
      $display("FAIL mid_reset: got rts=%b addr=%h op=%h err=%b want all 0", mem_rts_out, mem_addr, mem_op, rd_err);
    else passed++;
    rst = 1'b0;
    mem_rtr_in = 1'b1;
    set_req(1, 4'd1, 17'h00041, 32'h41);
    set_req(0, 4'd1, 17'h00040, 32'h40);
    total++; if (cli_rtr_out !== 3'b001) $display("FAIL mid_first: got %b want 001", cli_rtr_out); else passed++;
    step();
    clear_req();
    total++; if (mem_addr !== 17'h00040) $display("FAIL mid_addr: got %h want 00040", mem_addr); else passed++;
    mem_rd_valid_in = 1'b1;
    mem_rd_data_in  = 32'h77;
    step();
    mem_rd_valid_in = 1'b0;
    #1;
    total++; if (rd_err !== 1'b1 || cli_rd_valid !== 3'b000)
      $display("FAIL mid_stale_ret: got err=%b valid=%b want 1/000", rd_err, cli_rd_valid);
    else passed++;
  endtask

  initial begin
    rst             = 1'b1;
    cli_addr        = '0;
    cli_wr_data     = '0;
    cli_op          = '0;
    cli_rts_in      = '0;
    mem_rtr_in      = 1'b0;
    mem_rd_data_in  = '0;
    mem_rd_valid_in = 1'b0;
    test_reset();
    test_round_robin();
    test_single_write();
    test_stall();
    test_read_full();
    test_orphan_return();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
